// File: rtl/button_event_unit.sv
// Five-button synchronizer/debouncer producing one-hot {U,D,R,L,C} press pulses.
// Define BUTTON_AUTO_REPEAT_EN to compile in auto-repeat for held U/D.

module button_debounce #(
    parameter int DEBOUNCE_SAMPLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic tick,
    output logic level,
    output logic level_nxt,
    output logic rise
);
    logic [1:0] sync;
    logic [3:0] cnt;
    logic       flip;

    // The level flips on the DEBOUNCE_SAMPLES-th consecutive disagreeing tick.
    assign flip      = tick && (sync[1] != level) && (cnt == 4'(DEBOUNCE_SAMPLES - 1));
    assign level_nxt = level ^ flip;
    assign rise      = flip && !level;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync  <= {sync[0], raw};
            level <= level_nxt;
            if (tick) begin
                if (sync[1] == level || flip) cnt <= '0;
                else                          cnt <= cnt + 4'd1;
            end
        end
    end
endmodule

module button_event_unit #(
    parameter int TICK_DIV         = 500000,
    parameter int DEBOUNCE_SAMPLES = 4,
    parameter int REPEAT_DELAY     = 100,
    parameter int REPEAT_RATE      = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       C,
    input  logic       L,
    input  logic       R,
    input  logic       U,
    input  logic       D,
    output logic [4:0] btn_pulse,
    output logic [4:0] btn_level,
    output logic       repeat_evt,
    output logic       collision
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic [4:0]    raw, lvl_nxt, rise, winner;
    logic          multi, rpt_fire;

    assign raw  = {U, D, R, L, C};
    assign tick = (tick_cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + TW'(1);
    end

    for (genvar i = 0; i < 5; i++) begin : g_btn
        button_debounce #(.DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)) u_db (
            .clk      (clk),
            .rst      (rst),
            .raw      (raw[i]),
            .tick     (tick),
            .level    (btn_level[i]),
            .level_nxt(lvl_nxt[i]),
            .rise     (rise[i])
        );
    end

    // Lowest index wins, which is the C > L > R > D > U order of the vector.
    assign winner = rise & (~rise + 5'd1);
    assign multi  = (rise & (rise - 5'd1)) != 5'd0;

`ifdef BUTTON_AUTO_REPEAT_EN
    localparam int HW = $clog2(REPEAT_DELAY + 1);
    localparam int RW = (REPEAT_RATE > 1) ? $clog2(REPEAT_RATE + 1) : 1;

    logic [HW-1:0] hold_cnt;
    logic [RW-1:0] rate_cnt;
    logic          solo, hold_sat;

    // Judged on the post-tick level so a release or a new press stops repeats at once.
    assign solo     = (lvl_nxt == 5'b10000) || (lvl_nxt == 5'b01000);
    assign hold_sat = (hold_cnt == HW'(REPEAT_DELAY));
    assign rpt_fire = tick && (rise == 5'd0) && solo &&
                      ((hold_cnt == HW'(REPEAT_DELAY - 1)) ||
                       (hold_sat && rate_cnt == RW'(REPEAT_RATE - 1)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_cnt <= '0;
            rate_cnt <= '0;
        end else if (tick) begin
            if (rise != 5'd0 || !solo) begin
                hold_cnt <= '0;
                rate_cnt <= '0;
            end else if (!hold_sat) begin
                hold_cnt <= hold_cnt + HW'(1);
                rate_cnt <= '0;
            end else if (rate_cnt == RW'(REPEAT_RATE - 1)) begin
                rate_cnt <= '0;
            end else begin
                rate_cnt <= rate_cnt + RW'(1);
            end
        end
    end
`else
    logic unused_rpt;
    assign unused_rpt = ^{REPEAT_DELAY[0], REPEAT_RATE[0]};
    assign rpt_fire   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_pulse  <= '0;
            repeat_evt <= 1'b0;
            collision  <= 1'b0;
        end else begin
            btn_pulse  <= (rise != 5'd0) ? winner : (rpt_fire ? lvl_nxt : 5'd0);
            repeat_evt <= rpt_fire;
            collision  <= multi;
        end
    end
endmodule

// File: tb/tb_button_event_unit.sv
// Directed + randomized bench for button_event_unit against a tick-level behavioural model.
module tb_button_event_unit;
    localparam int TD = 4, DS = 3, RD = 5, RR = 2;
`ifdef BUTTON_AUTO_REPEAT_EN
    localparam bit RPT_EN = 1'b1;
`else
    localparam bit RPT_EN = 1'b0;
`endif

    logic       clk = 1'b0, rst = 1'b0;
    logic       C = 0, L = 0, R = 0, U = 0, D = 0;
    logic [4:0] btn_pulse, btn_level;
    logic       repeat_evt, collision;

    int ncmp = 0, nfail = 0;

    // model state
    int         k, hold;
    int         streak[5];
    logic [4:0] s0, s1, m_lvl, e_pulse;
    logic       e_rep, e_col;
    // observed event tallies for directed scenario checks
    int         pcnt[5];
    int         rcnt, ccnt;

    button_event_unit #(.TICK_DIV(TD), .DEBOUNCE_SAMPLES(DS),
                        .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
        .clk(clk), .rst(rst), .C(C), .L(L), .R(R), .U(U), .D(D),
        .btn_pulse(btn_pulse), .btn_level(btn_level),
        .repeat_evt(repeat_evt), .collision(collision)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        k = 0; hold = 0; s0 = '0; s1 = '0; m_lvl = '0;
        e_pulse = '0; e_rep = 1'b0; e_col = 1'b0;
        for (int i = 0; i < 5; i++) streak[i] = 0;
    endtask

    task automatic clr_cnt();
        for (int i = 0; i < 5; i++) pcnt[i] = 0;
        rcnt = 0; ccnt = 0;
    endtask

    task automatic set_btn(input logic [4:0] v);
        {U, D, R, L, C} = v;
    endtask

    // One clock edge of the model, using the button values present before the edge.
    task automatic model_edge();
        logic [4:0] nl, pr;
        int np, w;
        e_pulse = '0; e_rep = 1'b0; e_col = 1'b0;
        if (k % TD == TD - 1) begin
            nl = m_lvl; pr = '0;
            for (int i = 0; i < 5; i++) begin
                if (s1[i] != m_lvl[i]) begin
                    streak[i]++;
                    if (streak[i] == DS) begin
                        nl[i] = s1[i]; streak[i] = 0; pr[i] = s1[i];
                    end
                end else streak[i] = 0;
            end
            np = $countones(pr);
            if (np > 0) begin
                w = 0;
                for (int i = 4; i >= 0; i--) if (pr[i]) w = i;
                e_pulse = 5'(1 << w); e_col = (np > 1); hold = 0;
            end else if (RPT_EN && (nl == 5'b10000 || nl == 5'b01000)) begin
                hold++;
                if (hold == RD || (hold > RD && (hold - RD) % RR == 0)) begin
                    e_pulse = nl; e_rep = 1'b1;
                end
            end else hold = 0;
            m_lvl = nl;
        end
        s1 = s0; s0 = {U, D, R, L, C};
        k++;
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_edge();
        #1;
        chk("btn_pulse", btn_pulse, e_pulse);
        chk("btn_level", btn_level, m_lvl);
        chk("repeat_evt", repeat_evt, e_rep);
        chk("collision", collision, e_col);
        for (int i = 0; i < 5; i++) if (btn_pulse[i] === 1'b1 && repeat_evt !== 1'b1) pcnt[i]++;
        if (repeat_evt === 1'b1) rcnt++;
        if (collision === 1'b1) ccnt++;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b0;
        #1;
        model_reset();
        chk("rst_pulse", btn_pulse, 0);
        chk("rst_level", btn_level, 0);
        chk("rst_repeat", repeat_evt, 0);
        chk("rst_collision", collision, 0);
        repeat (cycles) step();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [4:0] v;
        int n;
        model_reset();
        clr_cnt();
        #2;
        chk("init_pulse", btn_pulse, 0);
        chk("init_level", btn_level, 0);
        chk("init_repeat", repeat_evt, 0);
        chk("init_collision", collision, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) step();

        // clean press/release of C
        clr_cnt(); set_btn(5'b00001);
        repeat (14) step();
        chk("c_press_latency", pcnt[0], 1);
        repeat (26) step();
        chk("c_press_once", pcnt[0], 1);
        chk("c_level", btn_level, 5'b00001);
        clr_cnt(); set_btn(5'b00000);
        repeat (40) step();
        chk("c_release_no_pulse", pcnt[0], 0);
        chk("c_release_level", btn_level, 5'b00000);

        // bouncing U, then settled
        clr_cnt();
        for (int i = 0; i < 10; i++) begin
            U = ~U;
            repeat (3) step();
        end
        chk("u_bounce_no_pulse", pcnt[4], 0);
        U = 1'b1;
        repeat (40) step();
        chk("u_settled_pulse", pcnt[4], 1);
        set_btn(5'b00000);
        repeat (40) step();

        // simultaneous L and U
        clr_cnt(); set_btn(5'b10010);
        repeat (40) step();
        chk("sim_l_pulse", pcnt[1], 1);
        chk("sim_u_dropped", pcnt[4], 0);
        chk("sim_collision", ccnt, 1);
        chk("sim_level", btn_level, 5'b10010);
        set_btn(5'b00000);
        repeat (40) step();

        // D held, then C pressed mid-hold
        clr_cnt(); set_btn(5'b01000);
        repeat (200) step();
        chk("d_press_once", pcnt[3], 1);
        chk("d_repeats_seen", (rcnt > 0), RPT_EN);
        clr_cnt(); set_btn(5'b01001);
        repeat (20) step();
        chk("c_mid_hold_pulse", pcnt[0], 1);
        clr_cnt();
        repeat (100) step();
        chk("repeats_stopped", rcnt, 0);
        set_btn(5'b00000);
        repeat (40) step();

        // reset while R debounces, R still held on release
        clr_cnt(); set_btn(5'b00100);
        repeat (6) step();
        do_reset(3);
        repeat (60) step();
        chk("r_after_reset_pulse", pcnt[2], 1);
        chk("r_after_reset_level", btn_level, 5'b00100);
        set_btn(5'b00000);
        repeat (40) step();

        // randomized held patterns, glitches and occasional resets
        for (int s = 0; s < 80; s++) begin
            case ($urandom_range(0, 5))
                0:       v = 5'b00000;
                1:       v = 5'b10000;
                2:       v = 5'b01000;
                3:       v = 5'(1 << $urandom_range(0, 4));
                default: v = 5'($urandom);
            endcase
            set_btn(v);
            if ($urandom_range(0, 15) == 0) do_reset($urandom_range(1, 4));
            n = $urandom_range(1, 60);
            repeat (n) step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
